// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO, runtime parity and configurable framing.
// Optional clear-to-send flow control is enabled by defining UART_TX_CTS_EN (adds port cts_n).
//   state  | meaning
//   IDLE   | line high, waiting for a queued byte
//   START  | start bit (low)
//   DATA   | data bits, LSB first
//   PARITY | even/odd parity bit
//   STOP   | stop bit(s) high, then chain to the next byte or go idle
module uart_tx_fifo #(
    parameter int FREQUENCY = 1_000_000,
    parameter int BAUDRATE  = 9600,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_BITS-1:0]   data,
    input  logic                   valid,
    output logic                   ready,
    input  logic [1:0]             parity_mode,
`ifdef UART_TX_CTS_EN
    input  logic                   cts_n,
`endif
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int CLKS_PER_BIT = FREQUENCY / BAUDRATE;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [LVL_W-1:0] FULL      = LVL_W'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 push;
    logic                 pop;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [BIT_W-1:0]     bit_q;
    logic [BIT_W-1:0]     bit_d;
    logic                 shift;
    logic                 tick;
    logic                 start_ok;
    logic                 cts_ok;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_en;
    logic                 par_bit;

    assign ready = (level != FULL);
    assign push  = valid && ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

`ifdef UART_TX_CTS_EN
    logic cts_s1;
    logic cts_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cts_s1 <= 1'b1;
            cts_s2 <= 1'b1;
        end else begin
            cts_s1 <= cts_n;
            cts_s2 <= cts_s1;
        end
    end

    assign cts_ok = ~cts_s2;
`else
    assign cts_ok = 1'b1;
`endif

    assign tick     = (cnt_q == '0);
    assign start_ok = (level != '0) && cts_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    // Parity is resolved at pop time so later parity_mode changes cannot touch the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
        end else if (pop) begin
            shreg   <= mem[rd_ptr];
            par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit <= (^mem[rd_ptr]) ^ (parity_mode == 2'b10);
        end else if (shift) begin
            shreg <= shreg >> 1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    pop     = 1'b1;
                    state_d = START;
                    cnt_d   = BIT_LOAD;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    cnt_d   = BIT_LOAD;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (bit_q == LAST_BIT) begin
                    state_d = par_en ? PARITY : STOP;
                    cnt_d   = par_en ? BIT_LOAD : STOP_LOAD;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                    shift = 1'b1;
                    cnt_d = BIT_LOAD;
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    cnt_d   = STOP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (start_ok) begin
                    pop     = 1'b1;
                    state_d = START;
                    cnt_d   = BIT_LOAD;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
            PARITY:  tx = par_bit;
            default: tx = 1'b1;
        endcase
    end

    assign busy = (state_q != IDLE) || (level != '0);

endmodule
